vec_logic_arbiter: RTL

//  Shares one 3-bit vector-logic unit (bitwise OR, logical OR, NOT, AND) between two requesters.

---
 rtl/vec_logic_arbiter_if.sv | 41 ++++
 rtl/vec_logic_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/vec_logic_arbiter_if.sv
// Bundle of request, response and status signals for vec_logic_arbiter.
// slave is the arbiter's view; master is the requester/consumer view.
interface vec_logic_arbiter_if #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8
);
   logic                 req0_valid;
   logic [1:0]           req0_op;
   logic [WIDTH-1:0]     req0_a;
   logic [WIDTH-1:0]     req0_b;
   logic                 req0_ready;
   logic                 req1_valid;
   logic [1:0]           req1_op;
   logic [WIDTH-1:0]     req1_a;
   logic [WIDTH-1:0]     req1_b;
   logic                 req1_ready;
   logic                 resp_valid;
   logic                 resp_id;
   logic [2*WIDTH-1:0]   resp_data;
   logic                 resp_ready;
   logic                 busy;
   logic [CNT_W-1:0]     done_count;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_data,
      output busy, done_count
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_data,
      input  busy, done_count
   );
endinterface

// File: rtl/vec_logic_arbiter.sv
// Round-robin arbiter sharing one vector-logic unit (OR, logical OR, NOT, AND)
// between two requesters; each operation runs accept -> execute -> respond.
module vec_logic_arbiter #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8
) (
   input logic                clk,
   input logic                reset,
   vec_logic_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]         state;
   logic               ptr;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               id_q;
   logic [2*WIDTH-1:0] data_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               grant0;
   logic               grant1;
   logic [2*WIDTH-1:0] result;

   // Contention goes to requester 0 unless the pointer favours requester 1.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (bus.req0_valid && (!bus.req1_valid || !ptr))
            grant0 = 1'b1;
         else if (bus.req1_valid)
            grant1 = 1'b1;
      end
   end

   always_comb begin
      result = '0;
      case (op_q)
         2'b00: result[WIDTH-1:0] = a_q | b_q;
         2'b01: result[0]         = (|a_q) || (|b_q);
         2'b10: result            = {~b_q, ~a_q};
         default: result[WIDTH-1:0] = a_q & b_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         id_q   <= 1'b0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0) begin
                  op_q  <= bus.req0_op;
                  a_q   <= bus.req0_a;
                  b_q   <= bus.req0_b;
                  id_q  <= 1'b0;
                  state <= EXEC;
               end else if (grant1) begin
                  op_q  <= bus.req1_op;
                  a_q   <= bus.req1_a;
                  b_q   <= bus.req1_b;
                  id_q  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               data_q <= result;
               state  <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  cnt_q <= cnt_q + 1'b1;
                  ptr   <= ~id_q;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_id    = id_q;
   assign bus.resp_data  = data_q;
   assign bus.busy       = (state != IDLE);
   assign bus.done_count = cnt_q;
endmodule
